// File: rtl/term_pkg.sv
// Shared types and elaboration helpers for the term sequencer.
package term_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUTPUT
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic bit widths_ok(input int dw, input int sw, input int tw);
        return (sw >= clog2(dw)) && (tw >= clog2(dw + 1));
    endfunction

endpackage

// File: rtl/term_lod.sv
// Leading-one detector: index of the highest set bit plus a nonzero flag.
module term_lod #(
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = 3
) (
    input  logic [DATA_WIDTH-1:0]  data,
    output logic [SHIFT_WIDTH-1:0] idx,
    output logic                   nz
);

    always_comb begin
        idx = '0;
        nz  = |data;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (data[i]) idx = SHIFT_WIDTH'(i);
        end
    end

endmodule

// File: rtl/term_sequencer.sv
// Decomposes signed operands MSB-first into power-of-two terms under a
// per-operand budget and reports pos-neg of the accumulator per group.
module term_sequencer
    import term_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int SHIFT_WIDTH    = 3,
    parameter int ACC_BIT_WIDTH  = 16,
    parameter int TERM_CNT_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_last,
    input  logic [TERM_CNT_WIDTH-1:0] budget,
    output logic                      acc_clr,
    output logic                      acc_en,
    output logic                      acc_sign,
    output logic [SHIFT_WIDTH-1:0]    acc_shift,
    input  logic [ACC_BIT_WIDTH-1:0]  acc_pos,
    input  logic [ACC_BIT_WIDTH-1:0]  acc_neg,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_BIT_WIDTH-1:0]  out_data,
    output logic [ACC_BIT_WIDTH-1:0]  out_terms
);

    if (!widths_ok(DATA_WIDTH, SHIFT_WIDTH, TERM_CNT_WIDTH)) begin : g_width_check
        $error("term_sequencer: SHIFT_WIDTH or TERM_CNT_WIDTH too narrow");
    end

    state_t                    state;
    state_t                    state_next;
    logic [DATA_WIDTH-1:0]     mag;
    logic [DATA_WIDTH-1:0]     in_mag;
    logic [DATA_WIDTH-1:0]     mag_cleared;
    logic                      neg;
    logic                      last;
    logic [TERM_CNT_WIDTH-1:0] left;
    logic [SHIFT_WIDTH-1:0]    lod_idx;
    logic                      lod_nz;
    logic                      accept;
    logic                      skip;
    logic                      op_done;

    term_lod #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_lod (
        .data(mag),
        .idx (lod_idx),
        .nz  (lod_nz)
    );

    // The most negative operand negates to itself, which reads correctly as unsigned.
    assign in_mag = in_data[DATA_WIDTH-1] ? (~in_data) + DATA_WIDTH'(1) : in_data;

    assign accept      = in_valid && in_ready;
    assign skip        = (in_mag == '0) || (budget == '0);
    assign mag_cleared = mag & ~(DATA_WIDTH'(1) << lod_idx);
    assign op_done     = (mag_cleared == '0) || (left == TERM_CNT_WIDTH'(1));

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        acc_en     = 1'b0;
        acc_sign   = 1'b0;
        acc_shift  = '0;
        acc_clr    = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = ~reset;
                if (accept) begin
                    if (!skip)        state_next = S_ISSUE;
                    else if (in_last) state_next = S_DRAIN;
                end
            end
            S_ISSUE: begin
                acc_en    = lod_nz;
                acc_sign  = ~neg;
                acc_shift = lod_idx;
                if (op_done) state_next = last ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: state_next = S_OUTPUT;
            S_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_clr    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mag       <= '0;
            neg       <= 1'b0;
            last      <= 1'b0;
            left      <= '0;
            out_data  <= '0;
            out_terms <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && accept) begin
                mag  <= in_mag;
                neg  <= in_data[DATA_WIDTH-1];
                last <= in_last;
                left <= budget;
            end else if (state == S_ISSUE) begin
                mag  <= mag_cleared;
                left <= left - TERM_CNT_WIDTH'(1);
                if (out_terms != '1) out_terms <= out_terms + ACC_BIT_WIDTH'(1);
            end else if (state == S_DRAIN) begin
                // Last term landed in the accumulator on the previous edge.
                out_data <= acc_pos - acc_neg;
            end else if (state == S_OUTPUT && out_ready) begin
                out_terms <= '0;
            end
        end
    end

endmodule

// File: tb/tb_term_sequencer.sv
// Directed bench for term_sequencer with a behavioural pos/neg accumulator.
module tb_term_sequencer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic [3:0]  budget;
    logic        acc_clr;
    logic        acc_en;
    logic        acc_sign;
    logic [2:0]  acc_shift;
    logic [15:0] acc_pos;
    logic [15:0] acc_neg;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [15:0] out_terms;

    int n_checks;
    int n_fail;
    int cyc;
    logic [3:0] tterm[$];
    int         tcyc[$];

    term_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .budget   (budget),
        .acc_clr  (acc_clr),
        .acc_en   (acc_en),
        .acc_sign (acc_sign),
        .acc_shift(acc_shift),
        .acc_pos  (acc_pos),
        .acc_neg  (acc_neg),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_terms(out_terms)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (reset || acc_clr) begin
            acc_pos <= '0;
            acc_neg <= '0;
        end else if (acc_en) begin
            if (acc_sign) acc_pos <= acc_pos + (16'd1 << acc_shift);
            else          acc_neg <= acc_neg + (16'd1 << acc_shift);
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (acc_en && !reset) begin
            tterm.push_back({acc_sign, acc_shift});
            tcyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] packed_terms();
        logic [31:0] v;
        v = '0;
        foreach (tterm[i]) v = (v << 4) | 32'(tterm[i]);
        return v;
    endfunction

    task automatic send(input logic [7:0] d, input logic l, input logic [3:0] b);
        int n;
        in_data  = d;
        in_last  = l;
        budget   = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic finish_group(input string tag, input logic [15:0] e_data,
                                input logic [15:0] e_terms, input int e_n,
                                input logic [31:0] e_pack);
        wait_out();
        check({tag, "_data"}, 32'(out_data), 32'(e_data));
        check({tag, "_terms"}, 32'(out_terms), 32'(e_terms));
        check({tag, "_nterm"}, 32'(tterm.size()), 32'(e_n));
        check({tag, "_seq"}, packed_terms(), e_pack);
        out_ready = 1'b1;
        #1;
        check({tag, "_clr"}, 32'(acc_clr), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_vdone"}, 32'(out_valid), 32'd0);
        check({tag, "_acc0"}, 32'({acc_pos, acc_neg}), 32'd0);
        check({tag, "_tclr"}, 32'(out_terms), 32'd0);
        tterm.delete();
        tcyc.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        budget    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_acc_en", 32'(acc_en), 32'd0);
        check("rst_acc_clr", 32'(acc_clr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_terms", 32'(out_terms), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        tterm.delete();
        tcyc.delete();

        // +13 budget 4: shifts 3,2,0 positive, back to back
        send(8'd13, 1'b1, 4'd4);
        wait_out();
        check("t1_consec", (tcyc.size() == 3) ? 32'(tcyc[2] - tcyc[0]) : 32'hFFFF_FFFF, 32'd2);
        finish_group("t1", 16'd13, 16'd3, 3, 32'hBA8);

        // -13 budget 2: truncated to shifts 3,2 negative
        send(8'hF3, 1'b1, 4'd2);
        finish_group("t2", 16'hFFF4, 16'd2, 2, 32'h32);

        // {+5, -3 last} budget 8
        send(8'd5, 1'b0, 4'd8);
        check("t3_ready_issue", 32'(in_ready), 32'd0);
        send(8'hFD, 1'b1, 4'd8);
        check("t3_ready_issue2", 32'(in_ready), 32'd0);
        finish_group("t3", 16'd2, 16'd4, 4, 32'hA810);

        // -128 budget 1
        send(8'h80, 1'b1, 4'd1);
        finish_group("t4", 16'hFF80, 16'd1, 1, 32'h7);

        // zero operand then zero budget
        send(8'd0, 1'b0, 4'd3);
        check("t5_ready_idle", 32'(in_ready), 32'd1);
        send(8'd7, 1'b1, 4'd0);
        finish_group("t5", 16'd0, 16'd0, 0, 32'h0);

        // result held while out_ready low
        send(8'd6, 1'b1, 4'd8);
        wait_out();
        in_valid = 1'b1;
        in_data  = 8'd9;
        in_last  = 1'b1;
        budget   = 4'd8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_hold_valid", 32'(out_valid), 32'd1);
            check("t6_hold_data", 32'(out_data), 32'd6);
            check("t6_hold_ready", 32'(in_ready), 32'd0);
            check("t6_hold_clr", 32'(acc_clr), 32'd0);
        end
        in_valid = 1'b0;
        finish_group("t6", 16'd6, 16'd2, 2, 32'hA9);

        // reset during ISSUE aborts the group
        send(8'd15, 1'b1, 4'd8);
        reset = 1'b1;
        @(negedge clk);
        check("t7_rst_ready", 32'(in_ready), 32'd0);
        check("t7_rst_en", 32'(acc_en), 32'd0);
        check("t7_rst_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        #1;
        check("t7_ready_after", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid || acc_en) seen = 1'b1;
        end
        check("t7_no_result", 32'(seen), 32'd0);
        tterm.delete();
        tcyc.delete();
        send(8'd3, 1'b1, 4'd8);
        finish_group("t7", 16'd3, 16'd2, 2, 32'h98);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
